instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Writer side of the instruction memory: receives a program as a byte stream from the UART receiver and writes it, one 32-bit word at a time, into the instruction memory at byte addresses 0, 4, 8, …. Loading stops at a halt word, which is also written so the CPU stops there. The block sits between the UART RX and the instruction-memory write port, and runs while the CPU is held off.

## Interface
- NBITS, 32, instruction word width and address width
- CELDAS, 60, instruction memory cells; valid write addresses are 0..CELDAS-1
- HALT_WORD, 32'hFFFF_FFFF, word that terminates loading
- TIMEOUT_CYCLES, 1_000_000, inter-byte timeout; used only with LOADER_TIMEOUT_EN
- Clocking: one clock; reset is synchronous and active-high.
- i_clk, in, 1, single clock
- i_reset, in, 1, synchronous reset, active-high
- i_start, in, 1, one-cycle pulse; arms a new load from address 0
- i_rx_data, in, 8, received byte
- i_rx_valid, in, 1, one-cycle strobe qualifying i_rx_data
- o_wr_en, out, 1, instruction memory write strobe, one cycle per word
- o_wr_addr, out, NBITS, byte address of the word (multiple of 4)
- o_wr_data, out, NBITS, word to write
- o_busy, out, 1, high in RECV and WRITE
- o_done, out, 1, high in DONE
- o_error, out, 1, high in ERROR
- o_word_count, out, 8, words written in the current load, including the halt word

## Operation
- States:
  - IDLE, RECV, WRITE, DONE, ERROR.
- Starting a load:
  - i_start in IDLE, DONE or ERROR → RECV.
  - On entry, clear the address, byte counter, word count, o_done and o_error.
  - i_start in RECV or WRITE is ignored.
- Receiving bytes (RECV):
  - Each i_rx_valid shifts in one byte, big-endian: the first byte lands in bits [31:24].
  - The 4th byte completes the word; the next state is WRITE.
- Writing a word (WRITE, one cycle):
  - o_wr_en=1, with o_wr_data = the assembled word and o_wr_addr = the current address.
  - o_word_count increments.
  - The address then advances by 4.
- Ending a load:
  - If the written word equals HALT_WORD, go to DONE; otherwise return to RECV.
- Overflow:
  - If a completed word's address is ≥ CELDAS, it is not written (o_wr_en stays 0).
  - The block goes to ERROR.
- Bytes while not receiving:
  - i_rx_valid in IDLE, DONE or ERROR is dropped.
- Byte arriving during WRITE:
  - An i_rx_valid in the WRITE cycle is accepted as byte 0 of the next word. No byte is lost.
  - If that WRITE is the halt word, the byte is dropped.
- Reset mid-operation:
  - Any partial word is discarded, and no write is issued in the reset cycle.
  - All state returns to IDLE.

## Timing
- Reset values:
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_error=0, o_word_count=0.
  - State is IDLE and the byte counter is 0.
- Latency:
  - 4th byte strobed at cycle N → o_wr_en high at cycle N+1 for exactly one cycle.
  - o_wr_addr and o_wr_data are valid in that same cycle; the memory captures them on the rising edge.
- i_start at cycle N → o_busy=1 at N+1.
- Halt word write at cycle N → o_done=1 and o_busy=0 at N+1. o_done holds until the next i_start or reset.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Back-to-back i_rx_valid on consecutive cycles is supported at full rate.

## Configuration
- LOADER_TIMEOUT_EN defined:
  - In RECV with 1–3 bytes buffered, a counter increments each cycle without i_rx_valid. Any i_rx_valid clears it.
  - Reaching TIMEOUT_CYCLES discards the partial word and goes to ERROR.
  - The counter does not run while 0 bytes are buffered.
- LOADER_TIMEOUT_EN undefined:
  - No counter exists; RECV waits indefinitely.
  - TIMEOUT_CYCLES is unused.

## Structure
- Shared package `instr_loader_pkg`:
  - State encoding constants (IDLE, RECV, WRITE, DONE, ERROR).
  - BYTES_PER_WORD=4 and ADDR_STEP=4.
  - Default HALT_WORD.
- Sub-module `byte_assembler`:
  - 32-bit big-endian shift register plus 2-bit byte counter.
  - Inputs: clear, byte strobe. Output: word-complete flag.
  - The FSM, address counter, overflow check and timeout stay in the top module.

## Test plan
- Normal load:
  - Reset, i_start, then bytes 00 24 00 04 | 00 01 F0 21 | FF FF FF FF.
  - Expect writes (0, 32'h0024_0004), (4, 32'h0001_F021), (8, 32'hFFFF_FFFF).
  - Expect o_done=1 and o_word_count=3.
- Burst timing:
  - 8 bytes on consecutive cycles, with byte 5 arriving in the first WRITE cycle.
  - Expect two writes, each one cycle after its 4th byte, and correct data.
- Overflow:
  - Send 16 non-halt words with CELDAS=60.
  - Expect 15 writes (addresses 0..56), no write at 60, and o_error=1 with o_word_count=15.
- Reset mid-word:
  - After 2 bytes, assert i_reset; then i_start and send a full word.
  - Expect a single write at address 0 containing only the new bytes.
- Ignored inputs:
  - Bytes in IDLE produce no writes.
  - An i_start pulse in RECV leaves the address and byte counter unchanged.
- Timeout (LOADER_TIMEOUT_EN defined, TIMEOUT_CYCLES=100):
  - 3 bytes then silence → o_error=1 after 100 idle cycles, with no write.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRecv,
      StWrite,
      StDone,
      StError
   } loader_state_e;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned ADDR_STEP      = 4;

   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word assembler. The first three bytes are held in a shift
// register; the fourth is taken straight from the input so the complete word is
// available in the same cycle as its last strobe.
module byte_assembler
   import instr_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_strobe,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic [1:0]  o_byte_cnt,
   output logic        o_word_complete
);

   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   logic [23:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;

   // Next shift/count state; clear wins over a coincident strobe
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (i_clear) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (i_strobe) begin
         shift_d = {shift_q[15:0], i_byte};
         cnt_d   = cnt_q + 2'd1;  // wraps to 0 on the fourth byte
      end
   end

   // Shift register and byte counter
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_word          = {shift_q, i_byte};
   assign o_byte_cnt      = cnt_q;
   assign o_word_complete = i_strobe && !i_clear && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program from the UART byte stream into instruction memory, one word
// per write at byte addresses 0, 4, 8, ... until the halt word is written.
// Optional inter-byte timeout is enabled by defining LOADER_TIMEOUT_EN.
module instr_mem_loader
   import instr_loader_pkg::*;
#(
   parameter int unsigned      NBITS          = 32,
   parameter int unsigned      CELDAS         = 60,
   parameter logic [NBITS-1:0] HALT_WORD      = NBITS'(DEFAULT_HALT_WORD),
   parameter int unsigned      TIMEOUT_CYCLES = 1_000_000
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_valid,
   output logic             o_wr_en,
   output logic [NBITS-1:0] o_wr_addr,
   output logic [NBITS-1:0] o_wr_data,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error,
   output logic [7:0]       o_word_count
);

   loader_state_e    state_q, state_d;
   logic [NBITS-1:0] addr_q, addr_d;
   logic [NBITS-1:0] wr_data_q, wr_data_d;
   logic [7:0]       count_q, count_d;
   logic             wr_en_q, wr_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic             asm_clear;
   logic             asm_strobe;
   logic [31:0]      asm_word;
   logic [1:0]       asm_byte_cnt;
   logic             asm_complete;
   logic             tmo_expire;

   byte_assembler u_byte_assembler (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_clear         (asm_clear),
      .i_strobe        (asm_strobe),
      .i_byte          (i_rx_data),
      .o_word          (asm_word),
      .o_byte_cnt      (asm_byte_cnt),
      .o_word_complete (asm_complete)
   );

`ifdef LOADER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_run;

   // Count silent cycles only while a word is partially buffered
   always_comb begin
      tmo_run    = (state_q == StRecv) && (asm_byte_cnt != 2'd0) && !i_rx_valid;
      tmo_d      = tmo_run ? tmo_q + TMO_W'(1) : '0;
      tmo_expire = tmo_run && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
   end

   // Inter-byte timeout counter
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   logic unused_cfg;
   assign tmo_expire = 1'b0;
   assign unused_cfg = ^{asm_byte_cnt, 32'(TIMEOUT_CYCLES)};
`endif

   // Loader FSM next state, datapath updates and registered output values
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wr_data_d  = wr_data_q;
      count_d    = count_q;
      wr_en_d    = 1'b0;
      done_d     = done_q;
      error_d    = error_q;
      asm_clear  = 1'b0;
      asm_strobe = 1'b0;

      unique case (state_q)
         StIdle, StDone, StError: begin
            if (i_start) begin
               state_d   = StRecv;
               addr_d    = '0;
               count_d   = '0;
               done_d    = 1'b0;
               error_d   = 1'b0;
               asm_clear = 1'b1;
            end
         end
         StRecv: begin
            asm_strobe = i_rx_valid;
            if (asm_complete) begin
               if (addr_q >= NBITS'(CELDAS)) begin
                  state_d = StError;
                  error_d = 1'b1;
               end else begin
                  state_d   = StWrite;
                  wr_en_d   = 1'b1;
                  wr_data_d = NBITS'(asm_word);
               end
            end else if (tmo_expire) begin
               state_d   = StError;
               error_d   = 1'b1;
               asm_clear = 1'b1;
            end
         end
         StWrite: begin
            count_d = count_q + 8'd1;
            addr_d  = addr_q + NBITS'(ADDR_STEP);
            if (wr_data_q == HALT_WORD) begin
               state_d = StDone;
               done_d  = 1'b1;
            end else begin
               // A byte in the write cycle starts the next word
               state_d    = StRecv;
               asm_strobe = i_rx_valid;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d == StRecv) || (state_d == StWrite);
   end

   // State and output registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         wr_data_q <= '0;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         count_q   <= count_d;
         wr_en_q   <= wr_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign o_wr_en      = wr_en_q;
   assign o_wr_addr    = addr_q;
   assign o_wr_data    = wr_data_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_error      = error_q;
   assign o_word_count = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader.
module tb_instr_mem_loader;

   logic        i_clk;
   logic        i_reset;
   logic        i_start;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid;
   logic        o_wr_en;
   logic [31:0] o_wr_addr;
   logic [31:0] o_wr_data;
   logic        o_busy;
   logic        o_done;
   logic        o_error;
   logic [7:0]  o_word_count;

   int unsigned checks;
   int unsigned errors;

   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];

   instr_mem_loader #(
      .NBITS          (32),
      .CELDAS         (60),
      .HALT_WORD      (32'hFFFF_FFFF),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_rx_data    (i_rx_data),
      .i_rx_valid   (i_rx_valid),
      .o_wr_en      (o_wr_en),
      .o_wr_addr    (o_wr_addr),
      .o_wr_data    (o_wr_data),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_error      (o_error),
      .o_word_count (o_word_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Record every memory write
   always @(negedge i_clk) begin
      if (o_wr_en) begin
         wa_q.push_back(o_wr_addr);
         wd_q.push_back(o_wr_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      tick();
      tick();
      i_reset = 1'b0;
      wa_q.delete();
      wd_q.delete();
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   // One byte followed by an idle cycle
   task automatic send_byte_gap(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
      tick();
   endtask

   // Four bytes on consecutive cycles, MSB first
   task automatic send_word_burst(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         i_rx_data  = w[31-8*i -: 8];
         i_rx_valid = 1'b1;
         tick();
      end
      i_rx_valid = 1'b0;
   endtask

   task automatic check_write(input string tag, input int idx,
                              input logic [31:0] ea, input logic [31:0] ed);
      check({tag, "_addr"}, (idx < wa_q.size()) ? wa_q[idx] : 32'hDEAD_BEEF, ea);
      check({tag, "_data"}, (idx < wd_q.size()) ? wd_q[idx] : 32'hDEAD_BEEF, ed);
   endtask

   initial begin
      logic [7:0]  prog[12];
      logic [31:0] burst;

      checks     = 0;
      errors     = 0;
      i_reset    = 1'b0;
      i_start    = 1'b0;
      i_rx_data  = 8'h00;
      i_rx_valid = 1'b0;
      prog = '{8'h00, 8'h24, 8'h00, 8'h04, 8'h00, 8'h01, 8'hF0, 8'h21,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};

      // Reset values
      do_reset();
      check("rst_wr_en", 32'(o_wr_en), 32'd0);
      check("rst_addr", o_wr_addr, 32'd0);
      check("rst_data", o_wr_data, 32'd0);
      check("rst_flags", {29'd0, o_busy, o_done, o_error}, 32'd0);
      check("rst_count", 32'(o_word_count), 32'd0);

      // Bytes in IDLE are dropped
      send_word_burst(32'h1122_3344);
      tick();
      check("idle_writes", 32'(wa_q.size()), 32'd0);
      check("idle_busy", 32'(o_busy), 32'd0);

      // Normal load
      pulse_start();
      check("start_busy", 32'(o_busy), 32'd1);
      for (int i = 0; i < 12; i++) send_byte_gap(prog[i]);
      tick();
      check("norm_writes", 32'(wa_q.size()), 32'd3);
      check_write("norm_w0", 0, 32'd0, 32'h0024_0004);
      check_write("norm_w1", 1, 32'd4, 32'h0001_F021);
      check_write("norm_w2", 2, 32'd8, 32'hFFFF_FFFF);
      check("norm_done", {30'd0, o_done, o_busy}, 32'h2);
      check("norm_count", 32'(o_word_count), 32'd3);
      // Byte in DONE dropped; done holds
      send_byte_gap(8'h5A);
      check("done_drop", 32'(wa_q.size()), 32'd3);
      check("done_hold", 32'(o_done), 32'd1);
      pulse_start();
      check("restart_flags", {30'd0, o_done, o_busy}, 32'h1);
      check("restart_count", 32'(o_word_count), 32'd0);

      // Burst timing: byte 5 lands in the first WRITE cycle
      do_reset();
      pulse_start();
      burst = 32'h1122_3344;
      for (int i = 0; i < 4; i++) begin
         i_rx_data = burst[31-8*i -: 8];
         i_rx_valid = 1'b1;
         tick();
      end
      check("burst_wr0_en", 32'(o_wr_en), 32'd1);
      check("burst_wr0_addr", o_wr_addr, 32'd0);
      check("burst_wr0_data", o_wr_data, 32'h1122_3344);
      burst = 32'h5566_7788;
      for (int i = 0; i < 4; i++) begin
         i_rx_data = burst[31-8*i -: 8];
         i_rx_valid = 1'b1;
         tick();
         if (i == 0) check("burst_one_cycle", 32'(o_wr_en), 32'd0);
      end
      i_rx_valid = 1'b0;
      check("burst_wr1_en", 32'(o_wr_en), 32'd1);
      check("burst_wr1_addr", o_wr_addr, 32'd4);
      check("burst_wr1_data", o_wr_data, 32'h5566_7788);
      tick();
      check("burst_writes", 32'(wa_q.size()), 32'd2);
      check("burst_count", 32'(o_word_count), 32'd2);

      // Overflow: 16 non-halt words into 60 cells
      do_reset();
      pulse_start();
      for (int i = 0; i < 16; i++) send_word_burst(32'h1000_0000 + 32'(i));
      tick();
      tick();
      check("ovf_writes", 32'(wa_q.size()), 32'd15);
      check_write("ovf_last", 14, 32'd56, 32'h1000_000E);
      check("ovf_error", {30'd0, o_error, o_busy}, 32'h2);
      check("ovf_count", 32'(o_word_count), 32'd15);

      // Reset mid-word discards the partial bytes
      do_reset();
      pulse_start();
      send_byte_gap(8'hAA);
      send_byte_gap(8'hBB);
      do_reset();
      check("midrst_busy", 32'(o_busy), 32'd0);
      pulse_start();
      send_word_burst(32'h0102_0304);
      tick();
      check("midrst_writes", 32'(wa_q.size()), 32'd1);
      check_write("midrst_w0", 0, 32'd0, 32'h0102_0304);

      // i_start while receiving is ignored
      do_reset();
      pulse_start();
      send_byte_gap(8'hC1);
      send_byte_gap(8'hC2);
      pulse_start();
      send_byte_gap(8'hC3);
      send_byte_gap(8'hC4);
      check("ign_writes", 32'(wa_q.size()), 32'd1);
      check_write("ign_w0", 0, 32'd0, 32'hC1C2_C3C4);

`ifdef LOADER_TIMEOUT_EN
      // Timeout after 3 bytes and 100 silent cycles
      do_reset();
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         i_rx_data  = 8'h70 + 8'(i);
         i_rx_valid = 1'b1;
         tick();
      end
      i_rx_valid = 1'b0;
      repeat (99) tick();
      check("tmo_early", 32'(o_error), 32'd0);
      tick();
      check("tmo_error", 32'(o_error), 32'd1);
      check("tmo_writes", 32'(wa_q.size()), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
